instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Consumer end of the next-PC interface. Accepts each PC issued by the PC generator,
//  fetches the instruction word from instruction memory over a req/ack handshake, and
//  buffers {pc, instruction} pairs in a FIFO that feeds decode.
//  Sits between the PC unit, the instruction memory port and the decode stage.
//  A redirect (taken branch) is handled by flushing the queue and discarding any
//  in-flight fetch.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >=2
//  ADDR_W  32  PC / memory address width
//  DATA_W  32  instruction word width
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  pc_in       in   ADDR_W  PC to fetch
//  pc_valid    in   1       pc_in valid
//  pc_ready    out  1       block accepts pc_in this cycle
//  flush       in   1       redirect: drop queue contents and any in-flight fetch
//  imem_req    out  1       memory read request, held high until imem_ack
//  imem_addr   out  ADDR_W  word-aligned read address
//  imem_ack    in   1       memory returns imem_rdata this cycle
//  imem_rdata  in   DATA_W  instruction word
//  inst_valid  out  1       head entry valid
//  inst_ready  in   1       decode consumes head entry
//  inst_out    out  DATA_W  head instruction
//  inst_pc     out  ADDR_W  PC of head instruction (unaligned bits preserved)
//  fq_count    out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, FIFO empty.
//    imem_req=0, imem_addr=0, inst_valid=0, fq_count=0; inst_out/inst_pc=0.
//  - FSM states:
//    IDLE: no fetch outstanding.
//    REQ:  imem_req=1, waiting for imem_ack.
//    DROP: imem_req=1, waiting for imem_ack; returned data is discarded.
//  - pc_ready = (state==IDLE) & ~flush & (fq_count<DEPTH). Combinational; no other term.
//  - At most one outstanding fetch. Accepting in IDLE only guarantees a FIFO slot.
//  - Accept (pc_valid & pc_ready) at cycle N:
//    -> cycle N+1: imem_req=1, imem_addr={pc_in[ADDR_W-1:2],2'b00}; state REQ.
//    The pc is latched internally.
//  - REQ & imem_ack & ~flush: push {latched pc, imem_rdata}; imem_req=0 next cycle; -> IDLE.
//    The entry is visible on inst_valid the next cycle.
//    Minimum PC-accept to inst_valid latency is 2 cycles, with ack in N+1.
//  - imem_req/imem_addr are held stable while waiting for imem_ack.
//    imem_ack outside REQ/DROP is ignored.
//  - FIFO: inst_valid = (fq_count!=0); pop on inst_valid & inst_ready.
//    A simultaneous push and pop leaves the count unchanged.
//    Pointers wrap modulo DEPTH.
//  - Full: fq_count==DEPTH -> pc_ready=0; an outstanding fetch never overflows.
//  - flush (highest priority) in a cycle:
//    - FIFO cleared next cycle; any pop that cycle is ignored.
//    - No PC is accepted that cycle.
//    - IDLE stays IDLE.
//    - REQ & imem_ack: data discarded; -> IDLE.
//    - REQ & ~imem_ack: -> DROP.
//    - DROP & imem_ack: -> IDLE; otherwise stays DROP.
//  - DROP: ignores pc_valid (pc_ready=0); the returned data is discarded.
//  - Reset mid-fetch: imem_req drops immediately. The memory must tolerate an abandoned request.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//    - Adds output stall_cnt[31:0], reset 0.
//    - Increments each cycle pc_valid=1 & pc_ready=0; wraps at 2^32-1 -> 0.
//    - flush does not clear it.
//  FETCH_PERF_EN undefined: port and counter absent; behaviour otherwise identical.
// TESTING
//  1. Reset -> all outputs 0.
//     pc_in=0x100, imem_ack in the 1st req cycle, rdata=0xDEAD0001
//     -> inst_valid 2 cycles after accept, inst_out=0xDEAD0001, inst_pc=0x100.
//  2. inst_ready=0, 4 sequential PCs 0x0,0x4,0x8,0xC, ack latency 3
//     -> fq_count=4, pc_ready=0.
//     Drain -> order 0x0..0xC preserved, fq_count=0.
//  3. flush while REQ with ack delayed 2 cycles
//     -> state DROP, imem_req held, rdata discarded, inst_valid=0.
//     Next PC 0x200 fetched normally.
//  4. flush in the same cycle as imem_ack and an inst_ready pop with count=2
//     -> FIFO empty next cycle, ack data dropped, pc_ready=0 that cycle.
//  5. Random pc_valid/inst_ready/ack delays, with push and pop in the same cycle at full
//     -> no loss or duplication vs. reference queue; 8+ pointer wraps.
//     pc_in=0x103 -> imem_addr=0x100, inst_pc=0x103.
//  6. FETCH_PERF_EN: hold pc_valid 5 cycles while full -> stall_cnt=5.
//     rst_n pulse mid-fetch -> imem_req=0 asynchronously, stall_cnt=0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: accepts PCs, fetches words over imem req/ack, buffers {pc,inst} for decode.
// Optional FETCH_PERF_EN adds a stall_cnt output counting cycles with pc_valid held off.
module instr_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        pc_in,
  input  logic                     pc_valid,
  output logic                     pc_ready,
  input  logic                     flush,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_W-1:0]        imem_rdata,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [DATA_W-1:0]        inst_out,
  output logic [ADDR_W-1:0]        inst_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]              stall_cnt,
`endif
  output logic [$clog2(DEPTH):0]   fq_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  state_t                        r_state;
  logic                          r_req;
  logic [ADDR_W-1:0]             r_addr;
  logic [ADDR_W-1:0]             r_pc;
  logic [DEPTH-1:0][ADDR_W-1:0]  r_fpc;
  logic [DEPTH-1:0][DATA_W-1:0]  r_fdat;
  logic [PW-1:0]                 r_wptr, r_rptr;
  logic [CW-1:0]                 r_count;

  logic w_accept, w_push, w_pop;

  assign pc_ready = (r_state == S_IDLE) & ~flush & (r_count < CW'(DEPTH));
  assign w_accept = pc_valid & pc_ready;
  assign w_push   = (r_state == S_REQ) & imem_ack & ~flush;
  assign w_pop    = (r_count != '0) & inst_ready & ~flush;

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign inst_valid = (r_count != '0);
  assign inst_out   = r_fdat[r_rptr];
  assign inst_pc    = r_fpc[r_rptr];
  assign fq_count   = r_count;

  // Fetch FSM; imem_req/imem_addr are registered so they stay stable until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_pc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
          r_addr  <= {pc_in[ADDR_W-1:2], 2'b00};
          r_pc    <= pc_in;
        end
        S_REQ: begin
          if (imem_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end else if (flush) begin
            r_state <= S_DROP;
          end
        end
        S_DROP: if (imem_ack) begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // A push can never hit a full queue: a slot was guaranteed when the PC was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_fpc   <= '0;
      r_fdat  <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fpc[r_wptr]  <= r_pc;
        r_fdat[r_wptr] <= imem_rdata;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_stall;
  assign stall_cnt = r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_stall <= '0;
    else if (pc_valid & ~pc_ready) r_stall <= r_stall + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a reference queue tracking every push/pop.
module tb_instr_fetch_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_in = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [2:0]  fq_count;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
`endif

  instr_fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc),
`ifdef FETCH_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] mq[$];
  logic [63:0] pend;
  bit          push_pend = 1'b0;
  bit          rnd = 1'b0;
  logic [31:0] last_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score any pop before the edge, update the model, then check the count.
  task automatic cyc();
    logic [63:0] e;
    #1;
    if (inst_valid && inst_ready && !flush && rst_n) begin
      if (mq.size() == 0) chk("pop_unexpected", {63'd0, inst_valid}, 64'd0);
      else begin
        e = mq.pop_front();
        chk("head_pc", inst_pc, e[63:32]);
        chk("head_data", inst_out, e[31:0]);
      end
    end
    if (flush) mq.delete();
    else if (push_pend) mq.push_back(pend);
    @(posedge clk); #1;
    push_pend = 1'b0;
    if (rnd) inst_ready = ($urandom_range(0, 2) == 0);
    chk("count", fq_count, mq.size());
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input int lat);
    int n;
    n = 0;
    pc_in = pc; pc_valid = 1'b1; #1;
    while (!pc_ready && n < 200) begin cyc(); n++; end
    if (!pc_ready) chk("accept_timeout", {63'd0, pc_ready}, 64'd1);
    cyc();
    pc_valid = 1'b0;
    chk("req_up", imem_req, 1);
    chk("req_addr", imem_addr, {pc[31:2], 2'b00});
    last_addr = imem_addr;
    for (int i = 1; i < lat; i++) begin
      cyc();
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, {pc[31:2], 2'b00});
    end
    imem_ack = 1'b1; imem_rdata = data; pend = {pc, data}; push_pend = 1'b1;
    cyc();
    imem_ack = 1'b0;
    chk("req_drop", imem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // 1. reset and a single fetch with ack in the first request cycle
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_count", fq_count, 0);
    chk("rst_out", inst_out, 0);
    chk("rst_pc", inst_pc, 0);
`ifdef FETCH_PERF_EN
    chk("rst_stall", stall_cnt, 0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    fetch(32'h100, 32'hDEAD0001, 1);
    chk("t1_valid", inst_valid, 1);
    chk("t1_out", inst_out, 32'hDEAD0001);
    chk("t1_pc", inst_pc, 32'h100);
    chk("t1_count", fq_count, 1);
    inst_ready = 1'b1; cyc(); inst_ready = 1'b0;
    chk("t1_empty", inst_valid, 0);

    // 2. fill to full with ack latency 3, then drain in order
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 32'h1000 + 32'(i), 3);
    chk("t2_full", fq_count, 4);
    pc_valid = 1'b1; #1;
    chk("t2_ready_full", pc_ready, 0);
    pc_valid = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_order_pc", inst_pc, 32'(i * 4));
      chk("t2_order_data", inst_out, 32'h1000 + 32'(i));
      cyc();
    end
    inst_ready = 1'b0;
    chk("t2_drained", fq_count, 0);

    // 3. flush in REQ, ack two cycles later is discarded
    pc_in = 32'h300; pc_valid = 1'b1; #1;
    cyc();
    pc_valid = 1'b0;
    chk("t3_req", imem_req, 1);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("t3_drop_req", imem_req, 1);
    chk("t3_drop_addr", imem_addr, 32'h300);
    pc_in = 32'h999; pc_valid = 1'b1; #1;
    chk("t3_drop_ready", pc_ready, 0);
    cyc();
    pc_valid = 1'b0;
    chk("t3_drop_req2", imem_req, 1);
    imem_ack = 1'b1; imem_rdata = 32'hBADBAD00; cyc(); imem_ack = 1'b0;
    chk("t3_idle_req", imem_req, 0);
    chk("t3_no_valid", inst_valid, 0);
    fetch(32'h200, 32'h2222, 2);
    chk("t3_next_pc", inst_pc, 32'h200);
    chk("t3_next_data", inst_out, 32'h2222);
    inst_ready = 1'b1; cyc(); inst_ready = 1'b0;

    // 4. flush coinciding with ack and a pop while two entries are held
    fetch(32'h10, 32'hA, 1);
    fetch(32'h14, 32'hB, 1);
    chk("t4_count2", fq_count, 2);
    pc_in = 32'h18; pc_valid = 1'b1; #1;
    cyc();
    flush = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hC; inst_ready = 1'b1; #1;
    chk("t4_ready_flush", pc_ready, 0);
    cyc();
    flush = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0; pc_valid = 1'b0; #1;
    chk("t4_empty", fq_count, 0);
    chk("t4_no_valid", inst_valid, 0);
    chk("t4_req", imem_req, 0);
    chk("t4_idle", pc_ready, 1);

    // 5. unaligned PC, then randomized traffic against the reference queue
    fetch(32'h103, 32'h5103, 1);
    chk("t5_addr_align", last_addr, 32'h100);
    chk("t5_pc_keep", inst_pc, 32'h103);
    rnd = 1'b1;
    for (int k = 0; k < 40; k++) begin
      fetch(32'h4000 + 32'(k * 4), $urandom, int'($urandom_range(1, 3)));
      if ($urandom_range(0, 3) == 0) cyc();
    end
    rnd = 1'b0; inst_ready = 1'b1;
    n = 0;
    while (fq_count != 0 && n < 20) begin cyc(); n++; end
    inst_ready = 1'b0;
    chk("t5_drained", inst_valid, 0);

    // 6. reset, stall counting while full, reset mid-fetch
    rst_n = 1'b0; mq.delete(); #1;
    chk("t6_rst_count", fq_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef FETCH_PERF_EN
    chk("t6_stall0", stall_cnt, 0);
`endif
    for (int i = 0; i < 4; i++) fetch(32'h80 + 32'(i * 4), 32'h8000 + 32'(i), 1);
    pc_in = 32'h90; pc_valid = 1'b1;
    repeat (5) cyc();
    pc_valid = 1'b0;
    chk("t6_full", pc_ready, 0);
`ifdef FETCH_PERF_EN
    chk("t6_stall5", stall_cnt, 5);
`endif
    flush = 1'b1; cyc(); flush = 1'b0;
    pc_in = 32'h40; pc_valid = 1'b1; #1;
    cyc();
    pc_valid = 1'b0;
    chk("t6_req", imem_req, 1);
    rst_n = 1'b0; mq.delete(); #1;
    chk("t6_async_req", imem_req, 0);
    chk("t6_async_addr", imem_addr, 0);
`ifdef FETCH_PERF_EN
    chk("t6_stall_rst", stall_cnt, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
